// File: rtl/buffer_bank_burst_reader.sv
// Multi-bank on-chip buffer: independent per-bank write ports, burst reads that stream
// consecutive addresses from one bank (narrow bus) or from all banks in parallel (wide bus).
module buffer_bank_burst_reader #(
  parameter int NUM_BANKS = 9,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int LEN_W     = ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BANKS-1:0]        wr_en,
  input  logic [NUM_BANKS*ADDR_W-1:0] wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] wr_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_mode,
  input  logic [BANK_W-1:0]           cmd_bank,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [LEN_W-1:0]            cmd_len,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_single,
  output logic [NUM_BANKS*DATA_W-1:0] out_all,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        mode_q, mode_d;
  logic [BANK_W-1:0]           bank_q, bank_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [LEN_W-1:0]            remain_q, remain_d;
  logic                        drain_q, drain_d;
  logic                        rd_en;
  logic                        rd_last;

  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_last_q, s1_last_d;
  logic                        out_valid_q, out_valid_d;
  logic                        done_q, done_d;
  logic [DATA_W-1:0]           out_single_q, out_single_d;
  logic [NUM_BANKS*DATA_W-1:0] out_all_q, out_all_d;

  logic [DATA_W-1:0]           bank_rdata [NUM_BANKS];
  logic [NUM_BANKS*DATA_W-1:0] all_rdata;
  logic [DATA_W-1:0]           sel_rdata;

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign out_single = out_single_q;
  assign out_all    = out_all_q;

  // Banks: nonblocking write and read on the same edge give read-first behaviour.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rdata_q;

      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          mem[wr_addr[gi*ADDR_W +: ADDR_W]] <= wr_data[gi*DATA_W +: DATA_W];
        end
        if (rd_en) begin
          rdata_q <= mem[addr_q];
        end
      end

      assign bank_rdata[gi]                   = rdata_q;
      assign all_rdata[gi*DATA_W +: DATA_W]   = rdata_q;
    end
  endgenerate

  // Out-of-range bank index selects nothing and yields zero.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_q == BANK_W'(i)) begin
        sel_rdata = bank_rdata[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    drain_d  = drain_q;
    rd_en    = 1'b0;
    rd_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d   = cmd_mode;
          bank_d   = cmd_bank;
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_en   = 1'b1;
        rd_last = (remain_q == '0);
        if (rd_last) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          remain_d = remain_q - LEN_W'(1);
          addr_d   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Two cycles: the last read still has to cross both register stages.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d   = rd_en;
    s1_last_d    = rd_last;
    out_valid_d  = s1_valid_q;
    done_d       = s1_valid_q & s1_last_q;
    out_single_d = out_single_q;
    out_all_d    = out_all_q;
    if (s1_valid_q) begin
      if (mode_q) begin
        out_all_d = all_rdata;
      end else begin
        out_single_d = sel_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      bank_q       <= '0;
      addr_q       <= '0;
      remain_q     <= '0;
      drain_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      out_single_q <= '0;
      out_all_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      bank_q       <= bank_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      drain_q      <= drain_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      out_single_q <= out_single_d;
      out_all_q    <= out_all_d;
    end
  end

endmodule

// File: tb/tb_buffer_bank_burst_reader.sv
// Bench for buffer_bank_burst_reader: directed scenarios plus random bursts checked
// against a shadow memory and a cycle-position model of the burst output timing.
module tb_buffer_bank_burst_reader;
  localparam int NB    = 9;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int BW    = 4;
  localparam int LW    = 10;

  logic              clk;
  logic              rst_n;
  logic [NB-1:0]     wr_en;
  logic [NB*AW-1:0]  wr_addr;
  logic [NB*DW-1:0]  wr_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [BW-1:0]     cmd_bank;
  logic [AW-1:0]     cmd_addr;
  logic [LW-1:0]     cmd_len;
  logic              out_valid;
  logic [DW-1:0]     out_single;
  logic [NB*DW-1:0]  out_all;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    mem_m [NB][DEPTH];
  logic [DW-1:0]    exp_single;
  logic [NB*DW-1:0] exp_all;

  buffer_bank_burst_reader dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .out_valid(out_valid), .out_single(out_single), .out_all(out_all),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic write_word(input int b, input int a, input logic [DW-1:0] d);
    wr_en = '0;
    wr_en[b] = 1'b1;
    wr_addr[b*AW +: AW] = AW'(a);
    wr_data[b*DW +: DW] = d;
    mem_m[b][a] = d;
    @(negedge clk);
    wr_en = '0;
  endtask

  // Cycle c = number of posedges after the accepting edge, sampled at the negedge.
  task automatic run_burst(input bit mode, input int bank, input int addr, input int len,
                           input bit hold, input bit col, input int col_bank,
                           input int col_addr, input logic [DW-1:0] col_data,
                           input int abort_at);
    logic [DW-1:0]    ws [$];
    logic [NB*DW-1:0] wa [$];
    logic [NB*DW-1:0] v;
    bit               valid_e;
    for (int j = 0; j <= len; j++) begin
      int a;
      a = (addr + j) % DEPTH;
      ws.push_back((bank < NB) ? mem_m[bank][a] : '0);
      for (int i = 0; i < NB; i++) v[i*DW +: DW] = mem_m[i][a];
      wa.push_back(v);
    end
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_bank  = BW'(bank);
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    chk("cmd_ready_pre", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    if (col) begin
      wr_en = '0;
      wr_en[col_bank] = 1'b1;
      wr_addr[col_bank*AW +: AW] = AW'(col_addr);
      wr_data[col_bank*DW +: DW] = col_data;
    end
    for (int c = 0; c <= len + 3; c++) begin
      @(negedge clk);
      if (col && c == 1) begin
        wr_en = '0;
        mem_m[col_bank][col_addr] = col_data;
      end
      valid_e = (c >= 2) && (c <= len + 2);
      if (valid_e) begin
        if (mode) exp_all = wa[c-2];
        else      exp_single = ws[c-2];
      end
      chk("out_valid", out_valid, valid_e);
      chk("done", done, c == len + 2);
      chk("busy", busy, c <= len + 2);
      chk("cmd_ready", cmd_ready, c == len + 3);
      chk("out_single", out_single, exp_single);
      chk("out_all", out_all, exp_all);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        exp_single = '0;
        exp_all    = '0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_single", out_single, exp_single);
        chk("rst_out_all", out_all, exp_all);
        @(negedge clk);
        chk("rst_hold_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        return;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_bank  = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    exp_single = '0;
    exp_all    = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_out_single", out_single, 16'h0);
    chk("reset_out_all", out_all, exp_all);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1'b1);

    // Fill every bank with random data, all banks written in parallel.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = '1;
      for (int b = 0; b < NB; b++) begin
        logic [DW-1:0] d;
        d = DW'($urandom);
        wr_addr[b*AW +: AW] = AW'(a);
        wr_data[b*DW +: DW] = d;
        mem_m[b][a] = d;
      end
      @(negedge clk);
    end
    wr_en = '0;
    @(negedge clk);

    // Single-bank burst of 8 words.
    for (int a = 0; a < 8; a++) write_word(3, a, DW'(16'h0300 + a));
    run_burst(1'b0, 3, 0, 7, 1'b0, 1'b0, 0, 0, '0, -1);

    // All-bank single-word burst.
    for (int b = 0; b < NB; b++) write_word(b, 5, DW'((b << 8) | 5));
    run_burst(1'b1, 0, 5, 0, 1'b0, 1'b0, 0, 0, '0, -1);

    // Address wrap at the top of the bank.
    run_burst(1'b0, 0, 1022, 3, 1'b0, 1'b0, 0, 0, '0, -1);

    // Read/write collision: first burst sees old word, second sees new.
    write_word(2, 10, 16'hA11A);
    run_burst(1'b0, 2, 10, 0, 1'b0, 1'b1, 2, 10, 16'hB22B, -1);
    run_burst(1'b0, 2, 10, 0, 1'b0, 1'b0, 0, 0, '0, -1);

    // cmd_valid held through a burst: exactly one more accept after IDLE.
    run_burst(1'b0, 1, 100, 4, 1'b1, 1'b0, 0, 0, '0, -1);
    run_burst(1'b0, 1, 100, 4, 1'b0, 1'b0, 0, 0, '0, -1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_cmd_ready", cmd_ready, 1'b1);
    end

    // Reset on the third valid, then the same burst must still read intact data.
    run_burst(1'b1, 0, 200, 9, 1'b0, 1'b0, 0, 0, '0, 4);
    run_burst(1'b1, 0, 200, 9, 1'b0, 1'b0, 0, 0, '0, -1);

    // Random bursts with random writes in between; bank index may exceed NB-1.
    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        write_word($urandom_range(0, NB - 1), $urandom_range(0, DEPTH - 1), DW'($urandom));
      end
      run_burst(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, DEPTH - 1),
                $urandom_range(0, 19), 1'b0, 1'b0, 0, 0, '0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
